// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, result classes,
// divider FSM states and a small sign helper.
package ex_stage_pkg;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MOVZN = 8'h0B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;
  localparam logic [2:0] SEL_ARITH = 3'd4;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_t;

  // Two's-complement negate when neg is set; used both for taking
  // magnitudes of signed operands and for restoring result signs.
  function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX bundle: decoded operation in, GPR/HI-LO results and stall out.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i;
  logic [31:0] mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i;
  logic [31:0] wb_lo_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           mem_whilo_i, mem_hi_i, mem_lo_i, wb_whilo_i, wb_hi_i, wb_lo_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider. Works on magnitudes and fixes the
// signs when the last step completes; result = {remainder, quotient}.
module ex_stage_div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state_reg, state_next;
  logic [63:0] work_reg, work_next;
  logic [31:0] divisor_reg, divisor_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        neg_quot_reg, neg_quot_next;
  logic        neg_rem_reg, neg_rem_next;
  logic [63:0] result_reg, result_next;
  logic [32:0] partial;
  logic [32:0] diff;
  logic [63:0] work_step;

  // One restoring step: shift the remainder/quotient pair left, subtract
  // the divisor if it fits and shift in the quotient bit.
  always_comb begin
    partial = work_reg[63:31];
    diff    = partial - {1'b0, divisor_reg};
    if (diff[32]) begin
      work_step = {partial[31:0], work_reg[30:0], 1'b0};
    end else begin
      work_step = {diff[31:0], work_reg[30:0], 1'b1};
    end
  end

  // Next-state and datapath updates; annul overrides everything.
  always_comb begin
    state_next    = state_reg;
    work_next     = work_reg;
    divisor_next  = divisor_reg;
    cnt_next      = cnt_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (start) begin
          neg_quot_next = is_signed && (op1[31] ^ op2[31]);
          neg_rem_next  = is_signed && op1[31];
          cnt_next      = '0;
          if (op2 == ZERO_WORD) begin
            state_next = DIV_BYZERO;
          end else begin
            state_next   = DIV_ON;
            work_next    = {ZERO_WORD, cond_negate(op1, is_signed && op1[31])};
            divisor_next = cond_negate(op2, is_signed && op2[31]);
          end
        end
      end
      DIV_BYZERO: begin
        result_next = '0;
        state_next  = DIV_END;
      end
      DIV_ON: begin
        work_next = work_step;
        cnt_next  = cnt_reg + 6'd1;
        if (cnt_reg == 6'(DIV_STEPS - 1)) begin
          state_next  = DIV_END;
          result_next = {cond_negate(work_step[63:32], neg_rem_reg),
                         cond_negate(work_step[31:0], neg_quot_reg)};
        end
      end
      DIV_END: begin
        state_next = DIV_IDLE;
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
    if (annul) begin
      state_next = DIV_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= DIV_IDLE;
      work_reg     <= '0;
      divisor_reg  <= '0;
      cnt_reg      <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      work_reg     <= work_next;
      divisor_reg  <= divisor_next;
      cnt_reg      <= cnt_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
    end
  end

  assign result = result_reg;
  assign ready  = (state_reg == DIV_END);

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational logic/shift/move/HI-LO/multiply
// results plus a stalling iterative divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   bus
);

  logic [31:0] hi_res, lo_res;
  logic [31:0] logic_res, shift_res, move_res;
  logic [63:0] prod_s, prod_u;
  logic [31:0] wdata, hi_val, lo_val;
  logic        whilo;
  logic        is_div;
  logic [63:0] div_result;
  logic        div_ready;

  assign is_div = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);

  // The youngest in-flight HI/LO writer wins: MEM, then WB, then committed.
  always_comb begin
    hi_res = bus.hi_i;
    lo_res = bus.lo_i;
    if (bus.mem_whilo_i) begin
      hi_res = bus.mem_hi_i;
      lo_res = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_res = bus.wb_hi_i;
      lo_res = bus.wb_lo_i;
    end
  end

  // Per-class GPR results; unknown opcodes give zero.
  always_comb begin
    logic_res = ZERO_WORD;
    shift_res = ZERO_WORD;
    move_res  = ZERO_WORD;
    case (bus.aluop_i)
      OP_AND:   logic_res = bus.reg1_i & bus.reg2_i;
      OP_OR:    logic_res = bus.reg1_i | bus.reg2_i;
      OP_XOR:   logic_res = bus.reg1_i ^ bus.reg2_i;
      OP_NOR:   logic_res = ~(bus.reg1_i | bus.reg2_i);
      OP_SLL:   shift_res = bus.reg2_i << bus.reg1_i[4:0];
      OP_SRL:   shift_res = bus.reg2_i >> bus.reg1_i[4:0];
      OP_SRA:   shift_res = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
      OP_MOVZN: move_res  = bus.reg1_i;
      OP_MFHI:  move_res  = hi_res;
      OP_MFLO:  move_res  = lo_res;
      default:  ;
    endcase
  end

  // Both products are taken mod 2^64 after sign/zero extension.
  assign prod_s = {{32{bus.reg1_i[31]}}, bus.reg1_i} * {{32{bus.reg2_i[31]}}, bus.reg2_i};
  assign prod_u = {32'h0, bus.reg1_i} * {32'h0, bus.reg2_i};

  ex_stage_div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .is_signed (bus.aluop_i == OP_DIV),
    .op1       (bus.reg1_i),
    .op2       (bus.reg2_i),
    .annul     (bus.flush_i),
    .result    (div_result),
    .ready     (div_ready)
  );

  // Select the GPR result and the HI/LO write; everything is forced to
  // zero while reset is held.
  always_comb begin
    wdata  = ZERO_WORD;
    whilo  = 1'b0;
    hi_val = ZERO_WORD;
    lo_val = ZERO_WORD;
    case (bus.alusel_i)
      SEL_LOGIC: wdata = logic_res;
      SEL_SHIFT: wdata = shift_res;
      SEL_MOVE:  wdata = move_res;
      default:   ;
    endcase
    case (bus.aluop_i)
      OP_MTHI: begin
        whilo  = 1'b1;
        hi_val = bus.reg1_i;
        lo_val = lo_res;
      end
      OP_MTLO: begin
        whilo  = 1'b1;
        hi_val = hi_res;
        lo_val = bus.reg1_i;
      end
      OP_MULT: begin
        whilo           = 1'b1;
        {hi_val, lo_val} = prod_s;
      end
      OP_MULTU: begin
        whilo           = 1'b1;
        {hi_val, lo_val} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        if (div_ready && !bus.flush_i) begin
          whilo           = 1'b1;
          {hi_val, lo_val} = div_result;
        end
      end
      default: ;
    endcase
    if (rst) begin
      wdata  = ZERO_WORD;
      whilo  = 1'b0;
      hi_val = ZERO_WORD;
      lo_val = ZERO_WORD;
    end
  end

  assign bus.wdata_o    = wdata;
  assign bus.whilo_o    = whilo;
  assign bus.hi_o       = hi_val;
  assign bus.lo_o       = lo_val;
  assign bus.wd_o       = rst ? 5'd0 : bus.wd_i;
  assign bus.wreg_o     = rst ? 1'b0 : bus.wreg_i;
  assign bus.stallreq_o = !rst && is_div && !div_ready && !bus.flush_i;

endmodule
